// File: rtl/alu_exec_pkg.sv
// ALU execute-stage shared types: op enum, alu_op classes, funct codes.
// Macro ALU_EXEC_SLT_EN enables the SLT funct (0x2A); otherwise it is illegal.
package alu_exec_pkg;

   typedef enum logic [2:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_SLT,
      OP_ILLEGAL
   } alu_fn_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   function automatic alu_fn_e funct_decode(
      input logic [5:0] f
   );
      alu_fn_e fn;
      fn = OP_ILLEGAL;
      case (f)
         FUNCT_ADD: fn = OP_ADD;
         FUNCT_SUB: fn = OP_SUB;
         FUNCT_AND: fn = OP_AND;
         FUNCT_OR:  fn = OP_OR;
`ifdef ALU_EXEC_SLT_EN
         FUNCT_SLT: fn = OP_SLT;
`endif
         default:   fn = OP_ILLEGAL;
      endcase
      return fn;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: add/sub with carry, and/or, optional SLT.
// Macro ALU_EXEC_SLT_EN adds the signed comparator for SLT.
module alu_core
   import alu_exec_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  alu_fn_e           fn_i,
   output logic [DATA_W-1:0] result_o,
   output logic              carry_o,
   output logic              zero_o
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] dif;

   assign sum = {1'b0, a_i} + {1'b0, b_i};
   assign dif = {1'b0, a_i} + {1'b0, ~b_i}
              + {{DATA_W{1'b0}}, 1'b1};

`ifdef ALU_EXEC_SLT_EN
   logic lt;
   assign lt = $signed(a_i) < $signed(b_i);
`endif

   // Select result and carry; illegal ops yield zero
   always_comb begin
      result_o = '0;
      carry_o  = 1'b0;
      case (fn_i)
         OP_ADD: begin
            result_o = sum[DATA_W-1:0];
            carry_o  = sum[DATA_W];
         end
         OP_SUB: begin
            result_o = dif[DATA_W-1:0];
            carry_o  = dif[DATA_W];
         end
         OP_AND: result_o = a_i & b_i;
         OP_OR:  result_o = a_i | b_i;
`ifdef ALU_EXEC_SLT_EN
         OP_SLT: result_o = {{(DATA_W-1){1'b0}}, lt};
`endif
         default: begin
            result_o = '0;
            carry_o  = 1'b0;
         end
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: op decode, B-operand mux, output registers.
// Macro ALU_EXEC_SLT_EN enables funct 0x2A (SLT); default build has no SLT.
module alu_exec_stage
   import alu_exec_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   input  logic [1:0]        alu_op_i,
   input  logic              alu_src_i,
   input  logic [DATA_W-1:0] reg_a_i,
   input  logic [DATA_W-1:0] reg_b_i,
   input  logic [DATA_W-1:0] imm_i,
   output logic [DATA_W-1:0] result_o,
   output logic              carry_o,
   output logic              zero_o,
   output logic              illegal_o
);

   logic [DATA_W-1:0] op_b;
   alu_fn_e           fn;

   logic [DATA_W-1:0] result_d, result_q;
   logic              carry_d, carry_q;
   logic              zero_d, zero_q;
   logic              illegal_d, illegal_q;

   assign op_b = alu_src_i ? imm_i : reg_b_i;

   // Decode main-control class, falling back to funct field
   always_comb begin
      fn = OP_ILLEGAL;
      unique case (1'b1)
         alu_op_i == ALUOP_ADD:   fn = OP_ADD;
         alu_op_i == ALUOP_SUB:   fn = OP_SUB;
         alu_op_i == ALUOP_OR:    fn = OP_OR;
         alu_op_i == ALUOP_FUNCT: fn = funct_decode(imm_i[5:0]);
         default:                 fn = OP_ILLEGAL;
      endcase
   end

   alu_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .a_i      (reg_a_i),
      .b_i      (op_b),
      .fn_i     (fn),
      .result_o (result_d),
      .carry_o  (carry_d),
      .zero_o   (zero_d)
   );

   assign illegal_d = (fn == OP_ILLEGAL);

   // Capture ALU outputs when enabled; reset wins over enable
   always_ff @(posedge clk) begin
      if (!reset) begin
         result_q  <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
      end else if (en_i) begin
         result_q  <= result_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign result_o  = result_q;
   assign carry_o   = carry_q;
   assign zero_o    = zero_q;
   assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vectors plus a
// cycle-level reference model. Honours ALU_EXEC_SLT_EN like the design.
module tb_alu_exec_stage;

   typedef struct packed {
      logic [31:0] r;
      logic        c;
      logic        z;
      logic        il;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [1:0]  alu_op;
   logic        alu_src;
   logic [31:0] reg_a;
   logic [31:0] reg_b;
   logic [31:0] imm;
   logic [31:0] result;
   logic        carry;
   logic        zero;
   logic        illegal;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t model;
   bit   model_valid = 1'b0;

   alu_exec_stage #(
      .DATA_W (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en_i      (en),
      .alu_op_i  (alu_op),
      .alu_src_i (alu_src),
      .reg_a_i   (reg_a),
      .reg_b_i   (reg_b),
      .imm_i     (imm),
      .result_o  (result),
      .carry_o   (carry),
      .zero_o    (zero),
      .illegal_o (illegal)
   );

   always #5 clk = ~clk;

   function automatic exp_t ref_alu(
      input logic [1:0]  op,
      input logic        src,
      input logic [31:0] a,
      input logic [31:0] rb,
      input logic [31:0] im
   );
      exp_t        e;
      logic [31:0] b;
      longint unsigned s;
      b = src ? im : rb;
      e = '0;
      case (op)
         2'b00: begin
            s = longint'(a) + longint'(b);
            e.r = s[31:0];
            e.c = (s >= 64'h1_0000_0000);
         end
         2'b01: begin
            e.r = a - b;
            e.c = (a >= b);
         end
         2'b11: e.r = a | b;
         default: begin
            case (im[5:0])
               6'h20: begin
                  s = longint'(a) + longint'(b);
                  e.r = s[31:0];
                  e.c = (s >= 64'h1_0000_0000);
               end
               6'h22: begin
                  e.r = a - b;
                  e.c = (a >= b);
               end
               6'h24: e.r = a & b;
               6'h25: e.r = a | b;
`ifdef ALU_EXEC_SLT_EN
               6'h2A: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`endif
               default: e.il = 1'b1;
            endcase
         end
      endcase
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   // reference register state, advanced on every rising edge
   always @(posedge clk) begin
      if (!reset) begin
         model       <= '{r: 32'd0, c: 1'b0, z: 1'b1, il: 1'b0};
         model_valid <= 1'b1;
      end else if (en) begin
         model <= ref_alu(alu_op, alu_src, reg_a, reg_b, imm);
      end
   end

   // per-cycle compare away from the active edge
   always @(negedge clk) begin
      if (model_valid) begin
         n_chk++;
         if ({result, carry, zero, illegal} !== model) begin
            n_fail++;
            $display("FAIL model t=%0t got r=%h c=%b z=%b il=%b want r=%h c=%b z=%b il=%b",
                     $time, result, carry, zero, illegal,
                     model.r, model.c, model.z, model.il);
         end
      end
   end

   task automatic drive(
      input logic        e,
      input logic [1:0]  op,
      input logic        s,
      input logic [31:0] a,
      input logic [31:0] b,
      input logic [31:0] im
   );
      en      = e;
      alu_op  = op;
      alu_src = s;
      reg_a   = a;
      reg_b   = b;
      imm     = im;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string       name,
      input logic [31:0] er,
      input logic        ec,
      input logic        ez,
      input logic        ei
   );
      n_chk++;
      if ({result, carry, zero, illegal} !== {er, ec, ez, ei}) begin
         n_fail++;
         $display("FAIL %s got r=%h c=%b z=%b il=%b want r=%h c=%b z=%b il=%b",
                  name, result, carry, zero, illegal, er, ec, ez, ei);
      end
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b1, 2'b00, 1'b0, 32'h1234, 32'h1, 32'h0);
      drive(1'b1, 2'b00, 1'b0, 32'h1234, 32'h1, 32'h0);
      chk("reset", 32'h0, 1'b0, 1'b1, 1'b0);
      reset = 1'b1;

      drive(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0);
      chk("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0);

      drive(1'b1, 2'b01, 1'b0, 32'h5, 32'h5, 32'h0);
      chk("sub_eq", 32'h0, 1'b1, 1'b1, 1'b0);

      drive(1'b1, 2'b01, 1'b0, 32'h3, 32'h5, 32'h0);
      chk("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

      drive(1'b1, 2'b10, 1'b0, 32'hF0F0, 32'h0FF0, 32'h24);
      chk("f_and", 32'h00F0, 1'b0, 1'b0, 1'b0);

      drive(1'b1, 2'b10, 1'b0, 32'hF0F0, 32'h0FF0, 32'h25);
      chk("f_or", 32'hFFF0, 1'b0, 1'b0, 1'b0);

      drive(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h2A);
`ifdef ALU_EXEC_SLT_EN
      chk("f_slt", 32'h1, 1'b0, 1'b0, 1'b0);
`else
      chk("f_slt_off", 32'h0, 1'b0, 1'b1, 1'b1);
`endif

      drive(1'b1, 2'b10, 1'b0, 32'h1, 32'h2, 32'h3F);
      chk("f_illegal", 32'h0, 1'b0, 1'b1, 1'b1);

      drive(1'b1, 2'b10, 1'b0, 32'h7, 32'h9, 32'h20);
      chk("f_add", 32'h10, 1'b0, 1'b0, 1'b0);

      drive(1'b1, 2'b10, 1'b0, 32'h9, 32'h7, 32'h22);
      chk("f_sub", 32'h2, 1'b1, 1'b0, 1'b0);

      drive(1'b1, 2'b00, 1'b1, 32'h10, 32'h5, 32'h20);
      chk("add_imm", 32'h30, 1'b0, 1'b0, 1'b0);

      drive(1'b1, 2'b11, 1'b1, 32'h0F00, 32'hAAAA, 32'h00FF);
      chk("ori", 32'h0FFF, 1'b0, 1'b0, 1'b0);

      drive(1'b0, 2'b00, 1'b0, 32'h1234, 32'h1, 32'h0);
      chk("hold1", 32'h0FFF, 1'b0, 1'b0, 1'b0);

      drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h3F);
      chk("hold2", 32'h0FFF, 1'b0, 1'b0, 1'b0);

      reset = 1'b0;
      drive(1'b0, 2'b00, 1'b0, 32'h2, 32'h3, 32'h0);
      chk("rst_no_en", 32'h0, 1'b0, 1'b1, 1'b0);

      reset = 1'b0;
      drive(1'b1, 2'b00, 1'b0, 32'h2, 32'h3, 32'h0);
      chk("rst_over_en", 32'h0, 1'b0, 1'b1, 1'b0);

      reset = 1'b1;
      drive(1'b1, 2'b00, 1'b0, 32'h2, 32'h3, 32'h0);
      chk("resume", 32'h5, 1'b0, 1'b0, 1'b0);

      drive(1'b1, 2'b01, 1'b0, 32'h0, 32'h1, 32'h0);
      chk("sub_under", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; every register updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port en_i, input, 1 bit, stage enable; 0 = hold all output registers.
REQ-005 SHALL have port alu_op_i, input, 2 bits, main-control ALU class.
REQ-006 SHALL have port alu_src_i, input, 1 bit, B-operand select: 0 = reg_b_i, 1 = imm_i.
REQ-007 SHALL have port reg_a_i, input, DATA_W bits, operand A.
REQ-008 SHALL have port reg_b_i, input, DATA_W bits, register operand B.
REQ-009 SHALL have port imm_i, input, DATA_W bits, extended immediate; bits [5:0] are the R-type funct field.
REQ-010 SHALL have port result_o, output, DATA_W bits, registered ALU result.
REQ-011 SHALL have port carry_o, output, 1 bit, registered carry-out.
REQ-012 SHALL have port zero_o, output, 1 bit, registered zero flag (result == 0).
REQ-013 SHALL have port illegal_o, output, 1 bit, registered flag for an undecodable funct.

Function
REQ-014 SHALL form operand B = alu_src_i ? imm_i : reg_b_i, combinationally.
REQ-015 SHALL decode alu_op_i as: 00 ADD, 01 SUB, 11 OR, 10 decode funct = imm_i[5:0].
REQ-016 SHALL decode funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (SLT only per REQ-027).
REQ-017 SHALL treat any other funct under alu_op_i = 10 as illegal: result 0, carry 0, zero 1, illegal 1.
REQ-018 SHALL compute ADD as A+B modulo 2^DATA_W, with carry = bit DATA_W of the (DATA_W+1)-bit sum.
REQ-019 SHALL compute SUB as A + ~B + 1, with carry = bit DATA_W (1 = no borrow); A == B gives result 0, carry 1.
REQ-020 SHALL compute AND/OR bitwise with carry 0; SLT gives {0..0, signed(A) < signed(B)} with carry 0.
REQ-021 SHALL set zero = (result == 0) for every operation, including illegal.
REQ-022 SHALL register result, carry, zero and illegal when en_i = 1 (latency exactly 1 clk); when en_i = 0 all outputs hold.
REQ-023 SHALL use no other state; outputs depend only on inputs sampled at the previous enabled edge.

Reset
REQ-024 SHALL, when reset = 0 at a rising clk edge, load result_o = 0, carry_o = 0, zero_o = 1, illegal_o = 0, irrespective of en_i.
REQ-025 SHALL give reset priority over en_i; a reset during operation discards the in-flight result.
REQ-026 SHALL resume normal capture on the first enabled edge with reset = 1.

Configuration
REQ-027 SHALL honour macro ALU_EXEC_SLT_EN: defined = funct 0x2A performs SLT; undefined = 0x2A is illegal per REQ-017 and no comparator logic is present.

Structure
REQ-028 SHALL place in package alu_exec_pkg: the ALU operation enum (ADD, SUB, AND, OR, SLT, ILLEGAL), the alu_op_i encodings, and the funct constants.
REQ-029 SHALL implement the combinational datapath in one sub-module, alu_core (operands plus op in, result/carry/zero out); decode, mux and registers sit in alu_exec_stage.

Verification
REQ-030 SHALL check: reset = 0 for 2 clks with en_i = 1 -> result 0, carry 0, zero 1, illegal 0.
REQ-031 SHALL check: alu_op 00, A = 0xFFFFFFFF, reg_b = 1, alu_src 0 -> next clk result 0, carry 1, zero 1.
REQ-032 SHALL check: alu_op 01, A = 5, reg_b = 5 -> result 0, carry 1, zero 1; then A = 3, reg_b = 5 -> result 0xFFFFFFFE, carry 0, zero 0.
REQ-033 SHALL check: alu_op 10, imm = 0x24, A = 0xF0F0, reg_b = 0x0FF0 -> result 0x00F0; imm = 0x25 -> result 0xFFF0.
REQ-034 SHALL check: alu_op 10, imm = 0x2A, A = 0xFFFFFFFF, reg_b = 1 -> result 1 with ALU_EXEC_SLT_EN, else illegal 1 and result 0; imm = 0x3F -> illegal 1.
REQ-035 SHALL check: alu_op 11, alu_src 1, imm = 0x00FF, A = 0x0F00 -> result 0x0FFF; then en_i = 0 with new inputs -> outputs unchanged.
